gray_step_arbiter: RTL and testbench
====================================

Name: gray_step_arbiter

Overview:
- Round-robin arbiter that shares one Gray-code step counter among N_REQ requesters.
- Each grant advances the shared counter by exactly one step. The grantee ID and the new Gray value are returned in the same cycle.
- Sits in front of the Gray counter datapath and replaces per-client enables with a single arbitrated step stream.
- Handles wrap-around with a sticky overflow flag and a one-cycle grant blackout after each wrap.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 3, counter width in bits.
- IDW, 2, grant ID width; must equal clog2(N_REQ).

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  N_REQ  level requests, one bit per requester.
- Clr  input  1  synchronous clear of count and overflow; lower priority than Reset.
- Gnt  output  N_REQ  one-hot grant pulse, registered.
- GntValid  output  1  high when Gnt is non-zero.
- GntId  output  IDW  index of the granted requester; 0 when GntValid=0.
- Output  output  WIDTH  Gray code of the binary count, bin ^ (bin>>1).
- Overflow  output  1  sticky; set on wrap from 2^WIDTH-1 to 0.
- Lock  input  1  present only with GRAY_ARB_LOCK_EN.

Behaviour:
- Reset (synchronous, active-high; clock Clk):
  - bin=0, so Output=0.
  - Overflow=0, Gnt=0, GntValid=0, GntId=0.
  - Round-robin pointer ptr=0; state=IDLE.
- FSM states IDLE, GRANT, WRAP. All outputs are registered.
- IDLE or GRANT, Clr=0, Req!=0, at the next edge:
  - Winner = first set Req bit searching ptr, ptr+1, ... modulo N_REQ.
  - Gnt=onehot(winner), GntValid=1, GntId=winner.
  - bin=bin+1, mod 2^WIDTH; ptr=(winner+1) mod N_REQ.
  - If the old bin was 2^WIDTH-1: Overflow=1 and state=WRAP. Otherwise state=GRANT.
- IDLE or GRANT, Req=0, at the next edge:
  - Gnt=0, GntValid=0, GntId=0; state=IDLE.
  - bin and ptr unchanged.
- WRAP:
  - Req is ignored for one cycle.
  - At the next edge: Gnt=0, GntValid=0, GntId=0; state=IDLE.
  - The first post-wrap grant appears two edges after the wrapping grant.
- Latency:
  - Request visible at edge k, Gnt high in cycle k+1.
  - Output and Overflow update on the same edge as Gnt.
  - Back-to-back grants are possible, one per cycle, outside WRAP.
- Requester rules:
  - A requester holds Req until it sees its Gnt bit.
  - Deasserting Req before a grant withdraws the request; no step is taken.
  - Holding Req high yields one grant per round-robin turn.
- Clr=1 (Reset=0), in any state:
  - At the next edge: bin=0, Overflow=0, Gnt=0, GntValid=0, GntId=0, state=IDLE.
  - ptr unchanged.
  - Clr beats simultaneous Req: no grant, no step.
- Reset mid-grant: Gnt drops at the next edge. No partial step persists.
- Overflow is cleared only by Reset or Clr. A second wrap leaves it at 1.
- Single requester: it is granted every cycle except the WRAP cycle.

Optional Feature:
- Macro GRAY_ARB_LOCK_EN.
- Defined:
  - Lock input exists.
  - If the current grantee keeps Req and Lock high, it is re-granted on consecutive cycles and ptr is not advanced.
  - WRAP still forces the one-cycle blackout; the lock survives WRAP if Req and Lock stay high.
  - Clr or Reset releases the lock.
- Undefined: no Lock port; pure round-robin.

Decomposition:
- Package gray_arb_pkg:
  - State enum: IDLE=2'd0, GRANT=2'd1, WRAP=2'd2.
  - Function bin2gray(bin).
  - Defaults N_REQ_DEF=4, WIDTH_DEF=3.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: Req, ptr.
  - Outputs: any, winner index.
  - Instantiated once.

Test Plan:
- Reset, then Req=4'b0001 held for 9 cycles:
  - Output sequence is 001,011,010,110,111,101,100,000.
  - Overflow rises with the 000 grant.
  - The next cycle has Gnt=0 (WRAP); a grant resumes one cycle after that with Output=001.
- Reset, then Req=4'b1111 held:
  - GntId sequence is 0,1,2,3,0.
  - Gnt is one-hot every cycle.
  - Output matches the Gray sequence from 001.
- Req=4'b1010 with ptr=0:
  - Grant to 1, then 3, then 1.
  - Drop Req[3] before its turn: next grants go only to 1.
- At count 5, assert Clr together with Req=4'b0001:
  - No grant; Output=000, Overflow=0.
  - The next grant gives Output=001.
- Assert Reset during a GRANT cycle while Req stays high:
  - All outputs are zero after the edge.
  - The first grant comes one cycle after Reset drops and goes to requester 0.
- With GRAY_ARB_LOCK_EN, Req=4'b0011, Lock=1 while requester 0 is granted:
  - Three consecutive grants go to 0.
  - Drop Lock: the next grant goes to 1.

Source files
------------

// File: rtl/gray_step_arbiter_pkg.sv
// Shared types and helpers for the Gray-step arbiter.
// Optional Lock support is enabled with `define GRAY_ARB_LOCK_EN.
package gray_arb_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRAP  = 2'd2
    } state_e;

    // Callers truncate the result to their own counter width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_step_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// Lock exists only when GRAY_ARB_LOCK_EN is defined.
interface gray_step_arbiter_if
    import gray_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDW   = $clog2(N_REQ_DEF)
);
    logic [N_REQ-1:0] Req;
    logic             Clr;
`ifdef GRAY_ARB_LOCK_EN
    logic             Lock;
`endif
    logic [N_REQ-1:0] Gnt;
    logic             GntValid;
    logic [IDW-1:0]   GntId;
    logic [WIDTH-1:0] Output;
    logic             Overflow;

    modport master (
`ifdef GRAY_ARB_LOCK_EN
        output Lock,
`endif
        output Req, Clr,
        input  Gnt, GntValid, GntId, Output, Overflow
    );

    modport slave (
`ifdef GRAY_ARB_LOCK_EN
        input  Lock,
`endif
        input  Req, Clr,
        output Gnt, GntValid, GntId, Output, Overflow
    );
endinterface

// File: rtl/gray_step_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             any,
    output logic [IDW-1:0]   winner
);
    int unsigned idx;

    always_comb begin
        any    = |req;
        winner = '0;
        idx    = 0;
        // Scan farthest-first so the nearest set bit to ptr is assigned last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) winner = IDW'(idx);
        end
    end
endmodule

// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter stepping a shared Gray counter once per grant.
// Define GRAY_ARB_LOCK_EN to let a grantee hold the grant via Lock.
module gray_step_arbiter
    import gray_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned IDW   = $clog2(N_REQ_DEF)
) (
    input logic               Clk,
    input logic               Reset,
    gray_step_arbiter_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             ovf_q, ovf_d;
    logic             pick_any;
    logic [IDW-1:0]   pick_winner;
    logic [IDW-1:0]   win;
    logic             lock_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req    (bus.Req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

`ifdef GRAY_ARB_LOCK_EN
    logic           lock_valid_q, lock_valid_d;
    logic [IDW-1:0] last_id_q, last_id_d;

    // last_id_q survives WRAP so a held lock resumes after the blackout.
    assign lock_hit = bus.Lock && lock_valid_q && bus.Req[last_id_q];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lock_valid_q <= 1'b0;
            last_id_q    <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            last_id_q    <= last_id_d;
        end
    end
`else
    assign lock_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        ovf_d       = ovf_q;
        win         = pick_winner;
`ifdef GRAY_ARB_LOCK_EN
        lock_valid_d = lock_valid_q;
        last_id_d    = last_id_q;
        if (lock_hit) win = last_id_q;
`endif
        if (bus.Clr) begin
            bin_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
`ifdef GRAY_ARB_LOCK_EN
            lock_valid_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, GRANT: begin
                    if (pick_any) begin
                        gnt_d[win]  = 1'b1;
                        gnt_valid_d = 1'b1;
                        gnt_id_d    = win;
                        bin_d       = bin_q + 1'b1;
                        if (!lock_hit) begin
                            ptr_d = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        end
                        if (bin_q == '1) begin
                            ovf_d   = 1'b1;
                            state_d = WRAP;
                        end else begin
                            state_d = GRANT;
                        end
`ifdef GRAY_ARB_LOCK_EN
                        lock_valid_d = 1'b1;
                        last_id_d    = win;
`endif
                    end else begin
                        state_d = IDLE;
`ifdef GRAY_ARB_LOCK_EN
                        lock_valid_d = 1'b0;
`endif
                    end
                end
                WRAP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        out_d = WIDTH'(bin2gray(32'(bin_d)));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            out_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.Gnt      = gnt_q;
    assign bus.GntValid = gnt_valid_q;
    assign bus.GntId    = gnt_id_q;
    assign bus.Output   = out_q;
    assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_gray_step_arbiter.sv
// Scoreboard bench: each driven cycle queues its expected post-edge outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_gray_step_arbiter;
    import gray_arb_pkg::*;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic       v;
        logic [1:0] id;
        logic [2:0] out;
        logic       ovf;
        string      tag;
    } exp_t;

    exp_t q[$];

    gray_step_arbiter_if #(.N_REQ(4), .WIDTH(3), .IDW(2)) bus ();

    gray_step_arbiter #(
        .N_REQ (4),
        .WIDTH (3),
        .IDW   (2)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin : monitor
        exp_t       e;
        logic [3:0] want_gnt;
        logic [3:0] one;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e        = q.pop_front();
                one      = 4'b0001;
                want_gnt = e.v ? (one << e.id) : 4'b0000;
                checks++;
                if (bus.Gnt !== want_gnt || bus.GntValid !== e.v || bus.GntId !== e.id ||
                    bus.Output !== e.out || bus.Overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s: got gnt=%b v=%b id=%0d out=%b ovf=%b, want gnt=%b v=%b id=%0d out=%b ovf=%b",
                             e.tag, bus.Gnt, bus.GntValid, bus.GntId, bus.Output, bus.Overflow,
                             want_gnt, e.v, e.id, e.out, e.ovf);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic clr, input logic [3:0] req,
                       input logic v, input logic [1:0] id, input logic [2:0] out,
                       input logic ovf, input string tag);
        exp_t e;
        @(negedge Clk);
        Reset   = rst;
        bus.Clr = clr;
        bus.Req = req;
        e.v = v; e.id = id; e.out = out; e.ovf = ovf; e.tag = tag;
        q.push_back(e);
    endtask

`ifdef GRAY_ARB_LOCK_EN
    initial bus.Lock = 1'b0;
`endif

    initial begin : driver
        Reset   = 1'b1;
        bus.Clr = 1'b0;
        bus.Req = 4'b0000;

        // Single requester through a full wrap and the blackout cycle
        cyc(1, 0, 4'b0000, 0, 0, 3'b000, 0, "reset");
        cyc(0, 0, 4'b0001, 1, 0, 3'b001, 0, "single1");
        cyc(0, 0, 4'b0001, 1, 0, 3'b011, 0, "single2");
        cyc(0, 0, 4'b0001, 1, 0, 3'b010, 0, "single3");
        cyc(0, 0, 4'b0001, 1, 0, 3'b110, 0, "single4");
        cyc(0, 0, 4'b0001, 1, 0, 3'b111, 0, "single5");
        cyc(0, 0, 4'b0001, 1, 0, 3'b101, 0, "single6");
        cyc(0, 0, 4'b0001, 1, 0, 3'b100, 0, "single7");
        cyc(0, 0, 4'b0001, 1, 0, 3'b000, 1, "wrap_grant");
        cyc(0, 0, 4'b0001, 0, 0, 3'b000, 1, "wrap_blackout");
        cyc(0, 0, 4'b0001, 1, 0, 3'b001, 1, "post_wrap");
        cyc(0, 0, 4'b0000, 0, 0, 3'b001, 1, "idle_sticky_ovf");
        cyc(0, 1, 4'b0000, 0, 0, 3'b000, 0, "clr_ovf");

        // All requesters: strict rotation
        cyc(1, 0, 4'b1111, 0, 0, 3'b000, 0, "reset2");
        cyc(0, 0, 4'b1111, 1, 0, 3'b001, 0, "rr0");
        cyc(0, 0, 4'b1111, 1, 1, 3'b011, 0, "rr1");
        cyc(0, 0, 4'b1111, 1, 2, 3'b010, 0, "rr2");
        cyc(0, 0, 4'b1111, 1, 3, 3'b110, 0, "rr3");
        cyc(0, 0, 4'b1111, 1, 0, 3'b111, 0, "rr4");

        // Sparse requests, then requester 3 withdraws before its turn
        cyc(1, 0, 4'b1010, 0, 0, 3'b000, 0, "reset3");
        cyc(0, 0, 4'b1010, 1, 1, 3'b001, 0, "sparse_1");
        cyc(0, 0, 4'b1010, 1, 3, 3'b011, 0, "sparse_3");
        cyc(0, 0, 4'b1010, 1, 1, 3'b010, 0, "sparse_1b");
        cyc(0, 0, 4'b0010, 1, 1, 3'b110, 0, "withdraw_1");
        cyc(0, 0, 4'b0010, 1, 1, 3'b111, 0, "withdraw_1b");

        // Count is 5: Clr beats a simultaneous request
        cyc(0, 1, 4'b0001, 0, 0, 3'b000, 0, "clr_vs_req");
        cyc(0, 0, 4'b0001, 1, 0, 3'b001, 0, "after_clr");

        // Reset in the middle of a grant run
        cyc(0, 0, 4'b1111, 1, 1, 3'b011, 0, "pre_reset");
        cyc(1, 0, 4'b1111, 0, 0, 3'b000, 0, "mid_reset");
        cyc(0, 0, 4'b1111, 1, 0, 3'b001, 0, "post_reset");
        cyc(0, 0, 4'b0000, 0, 0, 3'b001, 0, "idle");

`ifdef GRAY_ARB_LOCK_EN
        cyc(1, 0, 4'b0011, 0, 0, 3'b000, 0, "lk_reset");
        cyc(0, 0, 4'b0011, 1, 0, 3'b001, 0, "lk_first");
        @(negedge Clk);
        bus.Lock = 1'b1;
        q.push_back('{v: 1'b1, id: 2'd0, out: 3'b011, ovf: 1'b0, tag: "lk_hold1"});
        cyc(0, 0, 4'b0011, 1, 0, 3'b010, 0, "lk_hold2");
        @(negedge Clk);
        bus.Lock = 1'b0;
        q.push_back('{v: 1'b1, id: 2'd1, out: 3'b110, ovf: 1'b0, tag: "lk_release"});
`endif

        @(negedge Clk);
        bus.Req = 4'b0000;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge Clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
